minmax_frame_ctrl: RTL and testbench

MINMAX_FRAME_CTRL -- requirements
Module: minmax_frame_ctrl

---
 rtl/minmax_pkg.sv | 17 +
 rtl/minmax_frame_ctrl.sv | 110 +++++++++++
 tb/tb_minmax_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/minmax_pkg.sv
// Shared definitions for the min/max frame controller: default sample MSB,
// FSM state encoding and frame-length normalisation.
package minmax_pkg;

    localparam int MSB_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // A programmed length of zero behaves as a single-sample frame.
    function automatic logic [7:0] eff_len(input logic [7:0] l);
        return (l == 8'd0) ? 8'd1 : l;
    endfunction

endpackage

// File: rtl/minmax_frame_ctrl.sv
// Frames an input sample stream into an external min/max averager and
// returns one (min+max)/2 result per frame over a ready/valid handshake.
module minmax_frame_ctrl
    import minmax_pkg::*;
#(
    parameter int MSB = MSB_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [MSB:0] s_data,
    input  logic [7:0]   frame_len,
    input  logic         flush,
    output logic         mm_clear,
    output logic         mm_enable,
    output logic         mm_reset,
    output logic [MSB:0] mm_in,
    input  logic [MSB:0] mm_out,
    output logic         r_valid,
    input  logic         r_ready,
    output logic [MSB:0] r_data,
    output logic [7:0]   r_count
);

    state_t       state, state_nx;
    logic [7:0]   cnt, cnt_nx;
    logic [7:0]   len, len_nx;
    logic [7:0]   cur_len, cnt_inc;
    logic [MSB:0] held, held_nx;
    logic         accept, capture;

    // Stalling on an unconsumed result also keeps a frame's last sample from
    // overwriting it.
    assign s_ready  = !reset && !flush && (!r_valid || r_ready);
    assign accept   = s_valid && s_ready;
    assign mm_clear = reset | flush;

    assign cur_len = (state == IDLE) ? eff_len(frame_len) : len;
    assign cnt_inc = (state == IDLE) ? 8'd1 : cnt + 8'd1;
    assign capture = accept && (cnt_inc == cur_len);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        len_nx    = len;
        held_nx   = held;
        mm_enable = 1'b0;
        mm_reset  = 1'b0;
        mm_in     = '0;

        if (!reset) begin
            if (state == IDLE) begin
                if (accept) begin
                    mm_enable = 1'b1;
                    mm_reset  = 1'b1;
                    mm_in     = s_data;
                end
            end else begin
                // Re-feeding the last sample leaves the running min/max unchanged.
                mm_enable = 1'b1;
                mm_in     = accept ? s_data : held;
            end
        end

        if (flush) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (accept) begin
            held_nx = s_data;
            len_nx  = cur_len;
            if (capture) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                state_nx = ACC;
                cnt_nx   = cnt_inc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            len   <= '0;
            held  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            len   <= len_nx;
            held  <= held_nx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
        end else if (capture) begin
            r_valid <= 1'b1;
            r_data  <= mm_out;
            r_count <= cur_len;
        end else if (r_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_minmax_frame_ctrl.sv
// Bench for minmax_frame_ctrl: reference averager plus a queue-based frame model.
module tb_minmax_frame_ctrl;

    localparam int MSB = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [MSB:0] s_data = '0;
    logic [7:0]   frame_len = '0;
    logic         flush = 1'b0;
    logic         mm_clear, mm_enable, mm_reset;
    logic [MSB:0] mm_in, mm_out;
    logic         r_valid;
    logic         r_ready = 1'b1;
    logic [MSB:0] r_data;
    logic [7:0]   r_count;

    minmax_frame_ctrl #(.MSB(MSB)) dut (
        .clock(clock), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .frame_len(frame_len), .flush(flush),
        .mm_clear(mm_clear), .mm_enable(mm_enable), .mm_reset(mm_reset),
        .mm_in(mm_in), .mm_out(mm_out),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_count(r_count)
    );

    initial forever #5 clock = ~clock;

    // Reference min/max averager as the parent would instantiate it.
    logic [MSB:0]   av_min, av_max, c_min, c_max;
    logic [MSB+1:0] av_sum;
    always_comb begin
        if (mm_reset) begin
            c_min = mm_in;
            c_max = mm_in;
        end else begin
            c_min = (mm_in < av_min) ? mm_in : av_min;
            c_max = (mm_in > av_max) ? mm_in : av_max;
        end
        av_sum = {1'b0, c_min} + {1'b0, c_max};
        mm_out = av_sum[MSB+1:1];
    end
    always_ff @(posedge clock) begin
        if (mm_clear) begin
            av_min <= '1;
            av_max <= '0;
        end else if (mm_enable) begin
            av_min <= c_min;
            av_max <= c_max;
        end
    end

    // Frame model: samples of the open frame, and the pending result.
    int unsigned fr[$];
    int unsigned want_len = 0;
    bit          open = 0;
    bit          m_rv = 0;
    int unsigned m_rd = 0;
    int unsigned m_rc = 0;
    bit          accepted = 0;
    int unsigned hs = 0;

    int unsigned total = 0;
    int unsigned bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit           e_sready, acc, e_en, e_rst;
        logic [MSB:0] e_in;
        int unsigned  mn, mx;
        #1;
        e_sready = !reset && !flush && (!m_rv || r_ready);
        acc      = s_valid && e_sready;
        e_en     = !reset && (open || acc);
        e_rst    = !reset && !open && acc;
        e_in     = '0;
        if (!reset) begin
            if (acc) e_in = s_data;
            else if (open) e_in = fr[fr.size()-1][MSB:0];
        end
        chk("s_ready", s_ready, e_sready);
        chk("mm_clear", mm_clear, reset | flush);
        chk("mm_enable", mm_enable, e_en);
        chk("mm_reset", mm_reset, e_rst);
        chk("mm_in", mm_in, e_in);
        chk("r_valid", r_valid, m_rv);
        chk("r_data", r_data, m_rd);
        chk("r_count", r_count, m_rc);
        accepted = acc;
        if (r_valid === 1'b1 && r_ready) hs++;
        @(posedge clock);
        if (reset) begin
            open = 0; fr.delete();
            m_rv = 0; m_rd = 0; m_rc = 0;
        end else begin
            if (m_rv && r_ready) m_rv = 0;
            if (flush) begin
                open = 0; fr.delete();
            end else if (acc) begin
                if (!open) begin
                    want_len = (frame_len == 0) ? 1 : frame_len;
                    fr.delete();
                    open = 1;
                end
                fr.push_back(s_data);
                if (fr.size() == want_len) begin
                    mn = fr[0]; mx = fr[0];
                    foreach (fr[i]) begin
                        if (fr[i] < mn) mn = fr[i];
                        if (fr[i] > mx) mx = fr[i];
                    end
                    m_rv = 1; m_rd = (mn + mx) / 2; m_rc = want_len;
                    open = 0; fr.delete();
                end
            end
        end
        #1;
    endtask

    task automatic send(input int unsigned d);
        int unsigned n = 0;
        s_valid = 1'b1;
        s_data  = d[MSB:0];
        do begin
            cycle();
            n++;
        end while (!accepted && n < 40);
        chk("send_accepted", accepted, 1);
        s_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        s_valid = 1'b0;
        for (int unsigned i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned hs0;

        // Reset: first edge brings registers out of X, then checked cycles.
        @(posedge clock); #1;
        cycle();
        reset = 1'b0;
        chk("reset_rvalid", r_valid, 0);
        chk("reset_rdata", r_data, 0);
        chk("reset_rcount", r_count, 0);
        idle(2);

        // Four back-to-back samples.
        frame_len = 8'd4;
        send(10); send(200); send(50); send(30);
        chk("f4_data", r_data, 105);
        chk("f4_count", r_count, 4);
        idle(2);

        // Gaps inside a frame; frame_len change mid-frame is ignored.
        frame_len = 8'd3;
        send(5);
        frame_len = 8'd0;
        idle(3);
        send(9); send(7);
        chk("gap_data", r_data, 7);
        chk("gap_count", r_count, 3);
        idle(1);

        // frame_len=0 acts as single-sample frame.
        frame_len = 8'd0;
        send(77);
        chk("len0_data", r_data, 77);
        chk("len0_count", r_count, 1);
        idle(1);

        // Full-scale samples must not overflow.
        frame_len = 8'd2;
        send(511); send(511);
        chk("max_data", r_data, 511);
        idle(1);

        // Flush discards the open frame; only the following frame reports.
        hs0 = hs;
        frame_len = 8'd4;
        send(100); send(300);
        flush = 1'b1; cycle(); flush = 1'b0;
        frame_len = 8'd2;
        send(4); send(6);
        chk("flush_data", r_data, 5);
        idle(3);
        chk("flush_results", hs - hs0, 1);

        // Unconsumed result stalls the next sample until r_ready.
        r_ready = 1'b0;
        frame_len = 8'd1;
        send(33);
        chk("stall_rvalid", r_valid, 1);
        s_valid = 1'b1; s_data = 9'd44;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_sready", s_ready, 0);
        end
        r_ready = 1'b1;
        send(44);
        chk("stall_rdata", r_data, 44);
        chk("stall_rvalid2", r_valid, 1);
        idle(2);

        // Reset mid-frame yields no result.
        frame_len = 8'd4;
        send(1); send(2);
        reset = 1'b1; cycle(); reset = 1'b0;
        idle(5);
        chk("rst_mid_rvalid", r_valid, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            s_valid   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       s_data = '0;
                1:       s_data = '1;
                default: s_data = 9'($urandom_range(0, 511));
            endcase
            frame_len = 8'($urandom_range(0, 5));
            r_ready   = ($urandom_range(0, 3) != 0);
            cycle();
        end
        reset = 1'b0; flush = 1'b0; s_valid = 1'b0; r_ready = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
